decoder_rr_arbiter: RTL
=======================

# decoder_rr_arbiter

Round-robin arbiter for sixteen requesters sharing one resource. A 4-to-16 decoder turns the registered 4-bit winner index into a one-hot grant vector. The arbiter sits between the requesters and the shared datapath. It ensures exactly one requester, or none, is selected at a time, and it rotates priority so no requester starves.

## Interface
- `HOLD_MAX`, default 8: maximum number of cycles a grant may be held before forced release. Legal range 1..255. Used only when the timeout is compiled in.
- `clk` input 1: single clock, rising-edge active.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 16: request lines; bit i is requester i.
- `done` input 1: the granted requester asserts this to release the grant.
- `grant_valid` output 1: a grant is active this cycle.
- `grant_idx` output 4: index of the granted requester. Equals 0 when `grant_valid`=0.
- `grant` output 16: one-hot decode of `grant_idx`, gated by `grant_valid`. All zero when no grant is active.
- `timeout` output 1: one-cycle pulse when a grant is force-released.

## Operation
- Reset values:
  - state=IDLE, `grant_valid`=0, `grant_idx`=0, `grant`=0, `timeout`=0.
  - Priority pointer `ptr`=0.
  - Hold counter=0.
- The FSM has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - If `req`≠0, select the first set bit at or after `ptr`, scanning upward and wrapping 15→0.
  - Register the winner into `grant_idx`, set `grant_valid`=1, clear the hold counter, and go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT:
  - The hold counter increments every cycle, saturating at 255.
  - Release occurs when any of the following is true:
    - `done`=1;
    - `req[grant_idx]`=0 (requester withdrew);
    - timeout: counter reaches `HOLD_MAX`-1 with neither of the above (only when compiled in).
  - On release: go to RELEASE, set `grant_valid`=0, and set `ptr`=(`grant_idx`+1) mod 16. The 4-bit add wraps naturally, so 15+1=0.
  - The `timeout` pulse is asserted only when the timeout is the sole release cause. `done` takes precedence over timeout in the same cycle.
- RELEASE:
  - One dead cycle with `grant`=0 and `grant_idx`=0, so consecutive owners never overlap.
  - Unconditionally go to IDLE.
- Requests that change while in GRANT do not affect the current owner. Arbitration happens only in IDLE.
- `reset_n` low in any state (mid-grant included) immediately forces the reset values. The in-flight grant is dropped with no release cycle.
- The decoder is combinational from registered `grant_idx`/`grant_valid`, so `grant` is glitch-free relative to `clk`.

## Timing
- Request to grant: `req` seen in IDLE at edge n; `grant`/`grant_valid` high after edge n (1-cycle latency).
- `done` sampled at edge m; `grant_valid` low after edge m. The next grant appears no earlier than after edge m+2 (RELEASE, then IDLE arbitration).
- Minimum arbitration period: 3 cycles per owner (GRANT ≥1, RELEASE 1, IDLE 1).
- Timeout:
  - Grant issued at edge n; without `done`, `grant_valid` falls after edge n+`HOLD_MAX`.
  - `timeout` is high for exactly the cycle following that edge.
- All outputs are registered or decoded from registers. No combinational path exists from `req`/`done` to any output.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter and forced release are compiled in.
  - `timeout` pulses as specified above.
- `ARB_TIMEOUT_EN` not defined:
  - No hold counter.
  - A grant is held until `done` or request withdrawal, indefinitely if necessary.
  - `timeout` is tied to 0.
  - `HOLD_MAX` is ignored.

## Test plan
- Reset, then `req`=16'h0000 for 10 cycles → `grant`=0, `grant_valid`=0, `grant_idx`=0 throughout.
- `req`=16'h0011, pulse `done` one cycle after each grant → grant sequence 16'h0001, 16'h0010, 16'h0001, with a one-cycle gap of `grant`=0 between owners.
- Wrap-around: after requester 15 is served, `req`=16'h8001 → next grant is index 0 (`grant`=16'h0001), not 15.
- `ARB_TIMEOUT_EN` defined, `HOLD_MAX`=8, `req`=16'h0004 held high, `done`=0 → `grant`=16'h0004 for exactly 8 cycles, then a `timeout` pulse of 1 cycle. Regrant to index 2 follows after the RELEASE+IDLE cycles.
- Withdrawal: grant to index 5, then drop `req[5]` → `grant_valid` low on the next edge, with no `timeout` pulse.
- Reset mid-operation: assert `reset_n`=0 asynchronously while index 9 is granted → `grant`=0 immediately. After release, the first grant for `req`=16'hFFFF is index 0 (`ptr` reset).

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Sixteen-way round-robin arbiter with registered winner index decoded to a one-hot grant.
// Optional forced release after HOLD_MAX cycles is compiled in with `define ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [3:0]  idx_nxt;
  logic        valid_nxt;
  logic [3:0]  winner;
  logic [3:0]  cand;
  logic        found;
  logic        hold_expired;
  logic        release_now;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("decoder_rr_arbiter: HOLD_MAX must be in 1..255");
  end

  // First set request at or after ptr, wrapping 15 -> 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_fire;

  assign hold_expired = (hold_cnt == 8'(HOLD_MAX - 1));
  // Timeout only counts as the cause when neither done nor withdrawal applies.
  assign timeout_fire = (state == GRANT) && hold_expired && !done && req[grant_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_fire;
      if (state != GRANT)
        hold_cnt <= '0;
      else if (hold_cnt != 8'hFF)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign release_now = done || !req[grant_idx] || hold_expired;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    valid_nxt = grant_valid;
    idx_nxt   = grant_idx;
    unique case (state)
      IDLE: begin
        if (found) begin
          idx_nxt   = winner;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          idx_nxt   = '0;
          valid_nxt = 1'b0;
          ptr_nxt   = grant_idx + 4'd1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_valid <= valid_nxt;
      grant_idx   <= idx_nxt;
    end
  end

  assign grant = grant_valid ? (16'd1 << grant_idx) : '0;

endmodule
